// File: rtl/soc_timer_bank_if.sv
// Data bus port B bundle between a bus master and the timer bank.
interface soc_timer_bank_if;
  logic [31:0] addr_b;
  logic [31:0] data_b_in;
  logic        data_b_we;
  logic [31:0] data_b;
  logic        strobe_b;
  logic        irq;

  modport master (output addr_b, data_b_in, data_b_we, input data_b, strobe_b, irq);
  modport slave  (input addr_b, data_b_in, data_b_we, output data_b, strobe_b, irq);
endinterface

// File: rtl/soc_timer_bank.sv
// Bank of NCH memory-mapped timer/counter channels on data bus port B.
// Each channel has CTRL, COUNT, COMPARE and STATUS words, a prescaler,
// compare match with periodic or one-shot behaviour and a sticky match flag.
module soc_timer_bank #(
  parameter int unsigned BASE    = 65552,
  parameter int unsigned NCH     = 4,
  parameter int unsigned WIDTH   = 32,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  soc_timer_bank_if.slave bus
);

  localparam logic [31:0] LO_ADDR = 32'(BASE);
  localparam logic [31:0] HI_ADDR = 32'(BASE + 4 * NCH);

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_COUNT   = 2'd1,
    REG_COMPARE = 2'd2,
    REG_STATUS  = 2'd3
  } reg_sel_e;

  logic       in_range;
  logic [5:0] offset;
  logic [3:0] sel_ch;
  reg_sel_e   sel_reg;

  logic             en_q      [NCH];
  logic             oneshot_q [NCH];
  logic             irqen_q   [NCH];
  logic [7:0]       div_q     [NCH];
  logic [7:0]       pcnt_q    [NCH];
  logic [WIDTH-1:0] count_q   [NCH];
  logic [WIDTH-1:0] compare_q [NCH];
  logic             match_q   [NCH];

  logic             en_d      [NCH];
  logic             oneshot_d [NCH];
  logic             irqen_d   [NCH];
  logic [7:0]       div_d     [NCH];
  logic [7:0]       pcnt_d    [NCH];
  logic [WIDTH-1:0] count_d   [NCH];
  logic [WIDTH-1:0] compare_d [NCH];
  logic             match_d   [NCH];

  logic        irq_d;
  logic        irq_q;
  logic [31:0] rd_data;

  // Address decode: range check plus channel and register select within the bank
  always_comb begin
    in_range = (bus.addr_b >= LO_ADDR) && (bus.addr_b < HI_ADDR);
    offset   = 6'(bus.addr_b - LO_ADDR);
    sel_ch   = offset[5:2];
    sel_reg  = reg_sel_e'(offset[1:0]);
  end

  // Per-channel next state; ordering gives STATUS clear < tick < bus writes so set and writes win
  always_comb begin
    logic hit;
    logic tick;
    irq_d = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      hit  = bus.data_b_we && in_range && (sel_ch == 4'(c));
      tick = en_q[c] && (pcnt_q[c] == div_q[c]);

      en_d[c]      = en_q[c];
      oneshot_d[c] = oneshot_q[c];
      irqen_d[c]   = irqen_q[c];
      div_d[c]     = div_q[c];
      count_d[c]   = count_q[c];
      compare_d[c] = compare_q[c];
      match_d[c]   = match_q[c];
      pcnt_d[c]    = en_q[c] ? (tick ? 8'd0 : pcnt_q[c] + 8'd1) : 8'd0;

      if (hit && (sel_reg == REG_STATUS) && bus.data_b_in[0]) begin
        match_d[c] = 1'b0;
      end

      if (tick && !(hit && (sel_reg == REG_COUNT))) begin
        if (count_q[c] == compare_q[c]) begin
          match_d[c] = 1'b1;
          count_d[c] = '0;
          if (oneshot_q[c]) begin
            en_d[c] = 1'b0;
          end
        end else begin
          count_d[c] = count_q[c] + WIDTH'(1);
        end
      end

      if (hit) begin
        case (sel_reg)
          REG_CTRL: begin
            en_d[c]      = bus.data_b_in[0];
            oneshot_d[c] = bus.data_b_in[1];
            irqen_d[c]   = bus.data_b_in[2];
            div_d[c]     = bus.data_b_in[15:8];
            pcnt_d[c]    = 8'd0;
          end
          REG_COUNT:   count_d[c]   = bus.data_b_in[WIDTH-1:0];
          REG_COMPARE: compare_d[c] = bus.data_b_in[WIDTH-1:0];
          default: ;
        endcase
      end

      irq_d = irq_d | (match_d[c] & irqen_d[c]);
    end
  end

  // Channel state and interrupt registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        en_q[c]      <= 1'b0;
        oneshot_q[c] <= 1'b0;
        irqen_q[c]   <= 1'b0;
        div_q[c]     <= 8'd0;
        pcnt_q[c]    <= 8'd0;
        count_q[c]   <= '0;
        compare_q[c] <= '0;
        match_q[c]   <= 1'b0;
      end
      irq_q <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        en_q[c]      <= en_d[c];
        oneshot_q[c] <= oneshot_d[c];
        irqen_q[c]   <= irqen_d[c];
        div_q[c]     <= div_d[c];
        pcnt_q[c]    <= pcnt_d[c];
        count_q[c]   <= count_d[c];
        compare_q[c] <= compare_d[c];
        match_q[c]   <= match_d[c];
      end
      irq_q <= irq_d;
    end
  end

  // Read mux over the current register contents; zero outside the bank
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (in_range && (sel_ch == 4'(c))) begin
        case (sel_reg)
          REG_CTRL:    rd_data = {16'd0, div_q[c], 5'd0, irqen_q[c], oneshot_q[c], en_q[c]};
          REG_COUNT:   rd_data[WIDTH-1:0] = count_q[c];
          REG_COMPARE: rd_data[WIDTH-1:0] = compare_q[c];
          REG_STATUS:  rd_data = {30'd0, en_q[c], match_q[c]};
          default: ;
        endcase
      end
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      logic [31:0] data_q;
      logic        strobe_q;

      // Registered read path: one cycle from address to data/strobe
      always_ff @(posedge clk) begin
        if (!rst) begin
          data_q   <= 32'd0;
          strobe_q <= 1'b0;
        end else begin
          data_q   <= rd_data;
          strobe_q <= in_range;
        end
      end

      assign bus.data_b   = data_q;
      assign bus.strobe_b = strobe_q;
    end else begin : g_comb_out
      assign bus.data_b   = rd_data;
      assign bus.strobe_b = in_range;
    end
  endgenerate

  assign bus.irq = irq_q;

endmodule

// File: tb/tb_soc_timer_bank.sv
// Self-checking bench for soc_timer_bank: a registered-output 32-bit bank and a
// combinational-output 8-bit bank, checked against bench-computed expectations.
module tb_soc_timer_bank;

  localparam int unsigned BASE = 65552;
  localparam int unsigned NCH  = 4;
  localparam int unsigned NCH8 = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  soc_timer_bank_if bus0 ();
  soc_timer_bank_if bus8 ();

  soc_timer_bank #(.BASE(BASE), .NCH(NCH), .WIDTH(32), .REG_OUT(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  soc_timer_bank #(.BASE(BASE), .NCH(NCH8), .WIDTH(8), .REG_OUT(1'b0)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        strobe;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_strobe;
    string       name;
  } vec_t;

  exp_t sb0[$];
  exp_t sb8[$];
  vec_t vecs[$];

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] ra(int c, int r);
    return 32'(BASE + 4 * c + r);
  endfunction

  function automatic void addVec(bit we, logic [31:0] a, logic [31:0] wd,
                                 logic [31:0] ed, logic es, string nm);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd; v.exp_data = ed; v.exp_strobe = es; v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(bit we, logic [31:0] addr, logic [31:0] wdata);
    bus0.addr_b    = addr;
    bus0.data_b_in = wdata;
    bus0.data_b_we = we;
    step();
    bus0.data_b_we = 1'b0;
  endtask

  // Registered bank: expectation queued with the address, compared one edge later
  task automatic rd0(logic [31:0] addr, logic [31:0] exp, logic es, string name);
    exp_t e;
    e.name = name; e.data = exp; e.strobe = es;
    sb0.push_back(e);
    applyStimulus(1'b0, addr, 32'd0);
    e = sb0.pop_front();
    checkOutput({e.name, "_data"}, bus0.data_b, e.data);
    checkOutput({e.name, "_strobe"}, {31'd0, bus0.strobe_b}, {31'd0, e.strobe});
  endtask

  task automatic wr8(logic [31:0] addr, logic [31:0] wdata);
    bus8.addr_b    = addr;
    bus8.data_b_in = wdata;
    bus8.data_b_we = 1'b1;
    step();
    bus8.data_b_we = 1'b0;
  endtask

  // Combinational bank: compared in the same cycle the address is driven
  task automatic rd8(logic [31:0] addr, logic [31:0] exp, logic es, string name);
    exp_t e;
    e.name = name; e.data = exp; e.strobe = es;
    sb8.push_back(e);
    bus8.addr_b    = addr;
    bus8.data_b_we = 1'b0;
    #1;
    e = sb8.pop_front();
    checkOutput({e.name, "_data"}, bus8.data_b, e.data);
    checkOutput({e.name, "_strobe"}, {31'd0, bus8.strobe_b}, {31'd0, e.strobe});
    step();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp_cnt;

    bus0.addr_b = ra(0, 0); bus0.data_b_in = 32'd0; bus0.data_b_we = 1'b0;
    bus8.addr_b = 32'd0;    bus8.data_b_in = 32'd0; bus8.data_b_we = 1'b0;

    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 4; r++)
        addVec(1'b0, ra(c, r), 32'd0, 32'd0, 1'b1, $sformatf("reset_rd_c%0d_r%0d", c, r));
    addVec(1'b0, ra(NCH, 0), 32'd0, 32'd0, 1'b0, "oor_hi");
    addVec(1'b0, 32'(BASE - 1), 32'd0, 32'd0, 1'b0, "oor_lo");
    addVec(1'b1, ra(2, 2), 32'hDEADBEEF, 32'd0, 1'b0, "wr_cmp");
    addVec(1'b0, ra(2, 2), 32'd0, 32'hDEADBEEF, 1'b1, "rd_cmp");
    addVec(1'b1, ra(3, 0), 32'hFFFF0F06, 32'd0, 1'b0, "wr_ctrl");
    addVec(1'b0, ra(3, 0), 32'd0, 32'h00000F06, 1'b1, "rd_ctrl_reserved");
    addVec(1'b0, ra(3, 3), 32'd0, 32'd0, 1'b1, "rd_status_idle");
    addVec(1'b1, ra(3, 0), 32'd0, 32'd0, 1'b0, "wr_ctrl_off");
    addVec(1'b1, ra(2, 1), 32'h12345678, 32'd0, 1'b0, "wr_cnt");
    addVec(1'b0, ra(2, 1), 32'd0, 32'h12345678, 1'b1, "rd_cnt");
    addVec(1'b1, ra(2, 1), 32'd0, 32'd0, 1'b0, "wr_cnt0");
    addVec(1'b1, ra(2, 2), 32'd0, 32'd0, 1'b0, "wr_cmp0");
    addVec(1'b1, ra(1, 3), 32'hFFFFFFFF, 32'd0, 1'b0, "wr_status");
    addVec(1'b0, ra(1, 3), 32'd0, 32'd0, 1'b1, "rd_status_ro");

    $display("[TB] reset");
    repeat (3) step();
    checkOutput("reset_data", bus0.data_b, 32'd0);
    checkOutput("reset_strobe", {31'd0, bus0.strobe_b}, 32'd0);
    checkOutput("reset_irq", {31'd0, bus0.irq}, 32'd0);
    checkOutput("reset_irq8", {31'd0, bus8.irq}, 32'd0);
    rst = 1'b1;
    step();

    $display("[TB] register table");
    foreach (vecs[k]) begin
      if (vecs[k].we) applyStimulus(1'b1, vecs[k].addr, vecs[k].wdata);
      else rd0(vecs[k].addr, vecs[k].exp_data, vecs[k].exp_strobe, vecs[k].name);
    end

    $display("[TB] periodic channel 0");
    applyStimulus(1'b1, ra(0, 2), 32'd3);
    applyStimulus(1'b1, ra(0, 0), 32'h05);
    for (int i = 0; i < 6; i++) begin
      rd0(ra(0, 1), 32'(i % 4), 1'b1, $sformatf("per_cnt%0d", i));
      checkOutput($sformatf("per_irq%0d", i), {31'd0, bus0.irq}, (i + 1 >= 4) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b1, ra(0, 3), 32'd1);
    checkOutput("per_irq_cleared", {31'd0, bus0.irq}, 32'd0);
    rd0(ra(0, 3), 32'h2, 1'b1, "per_status_cleared");
    checkOutput("per_irq_again", {31'd0, bus0.irq}, 32'd1);
    rd0(ra(0, 3), 32'h3, 1'b1, "per_status_set");
    applyStimulus(1'b1, ra(0, 0), 32'd0);
    applyStimulus(1'b1, ra(0, 3), 32'd1);

    $display("[TB] status clear on match cycle");
    applyStimulus(1'b1, ra(2, 2), 32'd1);
    applyStimulus(1'b1, ra(2, 0), 32'h01);
    step();
    applyStimulus(1'b1, ra(2, 3), 32'd1);
    rd0(ra(2, 3), 32'h3, 1'b1, "coll_status_set_wins");
    applyStimulus(1'b1, ra(2, 0), 32'd0);
    applyStimulus(1'b1, ra(2, 3), 32'd1);

    $display("[TB] count write on tick");
    applyStimulus(1'b1, ra(3, 2), 32'd1000);
    applyStimulus(1'b1, ra(3, 0), 32'h01);
    applyStimulus(1'b1, ra(3, 1), 32'd100);
    rd0(ra(3, 1), 32'd100, 1'b1, "coll_cnt_write_wins");
    rd0(ra(3, 1), 32'd101, 1'b1, "coll_cnt_resume");
    applyStimulus(1'b1, ra(3, 0), 32'd0);

    $display("[TB] prescaled one-shot channel 1");
    applyStimulus(1'b1, ra(1, 2), 32'd2);
    applyStimulus(1'b1, ra(1, 0), 32'h0303);
    for (int i = 0; i < 14; i++) begin
      exp_cnt = (i < 4) ? 32'd0 : (i < 8) ? 32'd1 : (i < 12) ? 32'd2 : 32'd0;
      rd0(ra(1, 1), exp_cnt, 1'b1, $sformatf("os_cnt%0d", i));
    end
    rd0(ra(1, 0), 32'h0302, 1'b1, "os_ctrl_en_cleared");
    rd0(ra(1, 3), 32'h1, 1'b1, "os_status");
    checkOutput("os_irq_masked", {31'd0, bus0.irq}, 32'd0);

    $display("[TB] ctrl write on one-shot clear");
    applyStimulus(1'b1, ra(1, 3), 32'd1);
    applyStimulus(1'b1, ra(1, 0), 32'h03);
    step();
    step();
    applyStimulus(1'b1, ra(1, 0), 32'h03);
    rd0(ra(1, 0), 32'h3, 1'b1, "coll_ctrl_wins");
    rd0(ra(1, 3), 32'h3, 1'b1, "coll_ctrl_status");
    applyStimulus(1'b1, ra(1, 0), 32'd0);

    $display("[TB] read latency");
    rd0(32'(BASE - 1), 32'd0, 1'b0, "lat_pre");
    bus0.addr_b = ra(0, 1);
    #1;
    checkOutput("lat_same_cycle", {31'd0, bus0.strobe_b}, 32'd0);
    step();
    checkOutput("lat_next_cycle", {31'd0, bus0.strobe_b}, 32'd1);
    bus0.addr_b = 32'd0;
    step();
    checkOutput("lat_drop", {31'd0, bus0.strobe_b}, 32'd0);

    $display("[TB] 8-bit combinational bank");
    rd8(ra(0, 1), 32'd0, 1'b1, "w8_comb_strobe");
    wr8(ra(0, 2), 32'd255);
    wr8(ra(0, 1), 32'd254);
    wr8(ra(0, 0), 32'h01);
    rd8(ra(0, 1), 32'd254, 1'b1, "w8_cnt254");
    rd8(ra(0, 1), 32'd255, 1'b1, "w8_cnt255");
    rd8(ra(0, 1), 32'd0, 1'b1, "w8_cnt_wrap_match");
    rd8(ra(0, 3), 32'h3, 1'b1, "w8_status");
    wr8(ra(0, 0), 32'd0);
    wr8(ra(0, 1), 32'h1FF);
    rd8(ra(0, 1), 32'h000000FF, 1'b1, "w8_cnt_trunc");
    wr8(ra(1, 2), 32'hFFFFFF80);
    rd8(ra(1, 2), 32'h00000080, 1'b1, "w8_cmp_trunc");
    rd8(ra(NCH8, 0), 32'd0, 1'b0, "w8_oor_hi");
    rd8(32'(BASE - 1), 32'd0, 1'b0, "w8_oor_lo");

    $display("[TB] reset mid-count");
    applyStimulus(1'b1, ra(0, 2), 32'd50);
    applyStimulus(1'b1, ra(0, 0), 32'h05);
    repeat (5) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    rd0(ra(0, 1), 32'd0, 1'b1, "mid_rst_cnt");
    rd0(ra(0, 0), 32'd0, 1'b1, "mid_rst_ctrl");
    rd0(ra(0, 2), 32'd0, 1'b1, "mid_rst_cmp");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
